// File: rtl/dcsk_pkg.sv
// Shared definitions for the DCSK frame modulator: FSM encoding and the
// legal spreading-factor range.
package dcsk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REF  = 2'd1,
    ST_DATA = 2'd2
  } dcsk_state_t;

  localparam int MIN_SF_LOG2       = 1;
  localparam int MAX_SF_LOG2_LIMIT = 6;

endpackage

// File: rtl/dcsk_frame_modulator_chip_ref_buffer.sv
// One-bit-wide reference chip store: the chaotic chips of the REF half are
// written here and replayed, modulated, during the DATA half.
module chip_ref_buffer #(
  parameter int IDX_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic             i_wr_bit,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_bit
);

  localparam int DEPTH = 1 << IDX_W;

  logic [DEPTH-1:0] mem;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem <= '0;
    end else if (i_wr_en) begin
      mem[i_wr_idx] <= i_wr_bit;
    end
  end

  assign o_rd_bit = mem[i_rd_idx];

endmodule

// File: rtl/dcsk_frame_modulator.sv
// DCSK frame modulator: each message bit (MSB first) becomes SF chaotic
// reference chips followed by the same SF chips XORed with the bit.
module dcsk_frame_modulator
  import dcsk_pkg::*;
#(
  parameter int MSG_WIDTH   = 32,
  parameter int MAX_SF_LOG2 = 4,
  localparam int SFW        = $clog2(MAX_SF_LOG2 + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SFW-1:0]       i_sf_log2,
  input  logic [MSG_WIDTH-1:0] i_msg,
  input  logic                 i_msg_valid,
  output logic                 o_msg_ready,
  input  logic                 i_chaos_bit,
  output logic                 o_chaos_take,
  output logic                 o_chip,
  output logic                 o_chip_valid,
  input  logic                 i_chip_ready,
  output logic                 o_frame_start,
  output logic                 o_cfg_err
);

  localparam int CW = MAX_SF_LOG2;
  localparam int BW = $clog2(MSG_WIDTH);

  dcsk_state_t          state;
  logic [CW-1:0]        chip_idx;
  logic [CW-1:0]        chip_last;
  logic [CW:0]          sf_count;
  logic [BW-1:0]        bit_idx;
  logic [MSG_WIDTH-1:0] msg_reg;
  logic [SFW-1:0]       sf_reg;
  logic                 ref_bit;
  logic                 cur_bit;
  logic                 active;
  logic                 hs;
  logic                 ref_wr;

  assign o_cfg_err = (i_sf_log2 < SFW'(MIN_SF_LOG2)) | (i_sf_log2 > SFW'(MAX_SF_LOG2));

  // Outputs are gated by reset so nothing leaks out during the reset cycle itself.
  assign active    = (state != ST_IDLE) & ~i_rst;
  assign hs        = active & i_chip_ready;
  assign ref_wr    = hs & (state == ST_REF);
  assign sf_count  = (CW+1)'(1) << sf_reg;
  assign chip_last = CW'(sf_count - (CW+1)'(1));
  assign cur_bit   = msg_reg[bit_idx];

  assign o_msg_ready   = (state == ST_IDLE) & ~o_cfg_err & ~i_rst;
  assign o_chip_valid  = active;
  assign o_chaos_take  = ref_wr;
  assign o_chip        = active & ((state == ST_REF) ? i_chaos_bit : (ref_bit ^ cur_bit));
  assign o_frame_start = active & (state == ST_REF) & (chip_idx == '0)
                       & (bit_idx == BW'(MSG_WIDTH - 1));

  chip_ref_buffer #(
    .IDX_W (CW)
  ) u_ref_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (ref_wr),
    .i_wr_idx (chip_idx),
    .i_wr_bit (i_chaos_bit),
    .i_rd_idx (chip_idx),
    .o_rd_bit (ref_bit)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      chip_idx <= '0;
      bit_idx  <= '0;
      msg_reg  <= '0;
      sf_reg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_msg_valid && o_msg_ready) begin
            msg_reg  <= i_msg;
            sf_reg   <= i_sf_log2;
            bit_idx  <= BW'(MSG_WIDTH - 1);
            chip_idx <= '0;
            state    <= ST_REF;
          end
        end
        ST_REF: begin
          if (hs) begin
            if (chip_idx == chip_last) begin
              chip_idx <= '0;
              state    <= ST_DATA;
            end else begin
              chip_idx <= chip_idx + CW'(1);
            end
          end
        end
        ST_DATA: begin
          if (hs) begin
            if (chip_idx == chip_last) begin
              chip_idx <= '0;
              if (bit_idx == '0) begin
                state <= ST_IDLE;
              end else begin
                bit_idx <= bit_idx - BW'(1);
                state   <= ST_REF;
              end
            end else begin
              chip_idx <= chip_idx + CW'(1);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
